// File: rtl/instr_pack.sv
// instr_pack: shared register codes, data-memory widths and sequencer states.
package instr_pack;
    localparam int REG_W       = 3;
    localparam int DMEM_ADDR_W = 8;
    localparam int DMEM_DATA_W = 8;
    typedef enum logic [REG_W-1:0] {rega, regb, regc, regd, rege, regf, regg, regx} register;
    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_RESP, CLEAR} dmem_state_t;
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port synchronous RAM; the read data register only updates on re.
module dmem_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    assign rdata = rdata_q;
    always_ff @(posedge clk) begin
        if (we) mem_q[addr] <= wdata;
        if (re) rdata_q <= mem_q[addr];
    end
endmodule

// File: rtl/data_mem_unit.sv
// data_mem_unit: load/store sequencer around the data RAM with a single outstanding load and busy stall.
// Build option DMEM_CLEAR_EN zero-fills the RAM after every reset.
module data_mem_unit
    import instr_pack::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_req,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] st_data,
    input  register           ld_dst,
    output logic [DATA_W-1:0] loadData,
    output logic              loadEn,
    output register           loadDst,
    output logic              busy,
    output logic              req_err
);
    dmem_state_t       state_q;
    logic [1:0]        cnt_q;
    register           dst_q, ld_dst_q;
    logic [DATA_W-1:0] ld_data_q, ram_rdata, ram_wdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ld_en_q, busy_q, err_q, idle, ram_we, ram_re;
    assign idle   = state_q == IDLE;
    assign ram_re = ~reset & idle & ld_req & ~st_req;
`ifdef DMEM_CLEAR_EN
    localparam dmem_state_t RST_STATE = CLEAR;
    localparam logic        RST_BUSY  = 1'b1;
    logic [ADDR_W-1:0] clr_q;
    logic              clearing;
    assign clearing  = state_q == CLEAR;
    assign ram_we    = ~reset & (clearing | (idle & st_req));
    assign ram_addr  = clearing ? clr_q : addr;
    assign ram_wdata = clearing ? '0 : st_data;
`else
    localparam dmem_state_t RST_STATE = IDLE;
    localparam logic        RST_BUSY  = 1'b0;
    assign ram_we    = ~reset & idle & st_req;
    assign ram_addr  = addr;
    assign ram_wdata = st_data;
`endif
    assign loadData = ld_data_q;
    assign loadEn   = ld_en_q;
    assign loadDst  = ld_dst_q;
    assign busy     = busy_q;
    assign req_err  = err_q;
    dmem_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
        .clk(clk), .we(ram_we), .re(ram_re), .addr(ram_addr), .wdata(ram_wdata), .rdata(ram_rdata)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RST_STATE;
            cnt_q     <= '0;
            dst_q     <= rega;
            ld_dst_q  <= rega;
            ld_data_q <= '0;
            ld_en_q   <= 1'b0;
            busy_q    <= RST_BUSY;
            err_q     <= 1'b0;
`ifdef DMEM_CLEAR_EN
            clr_q     <= '0;
`endif
        end else begin
            ld_en_q <= 1'b0;
            // outside IDLE every request is illegal; in IDLE only the load+store collision is
            err_q   <= idle ? ld_req & st_req : ld_req | st_req;
            case (state_q)
                IDLE: if (ram_re) begin
                    dst_q   <= ld_dst;
                    cnt_q   <= 2'(RD_LAT - 1);
                    busy_q  <= 1'b1;
                    state_q <= RD_WAIT;
                end
                RD_WAIT: if (cnt_q == '0) state_q <= RD_RESP; else cnt_q <= cnt_q - 2'd1;
                RD_RESP: begin
                    ld_en_q   <= 1'b1;
                    ld_data_q <= ram_rdata;
                    ld_dst_q  <= dst_q;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
`ifdef DMEM_CLEAR_EN
                CLEAR: begin
                    clr_q <= clr_q + 1'b1;
                    if (clr_q == ADDR_W'(DEPTH - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_unit.sv
// tb_data_mem_unit: directed and randomized checks of data_mem_unit against a cycle-count reference model.
module tb_data_mem_unit;
    import instr_pack::*;
    localparam int RD_LAT = 1;
`ifdef DMEM_CLEAR_EN
    localparam logic RST_BUSY = 1'b1;
`else
    localparam logic RST_BUSY = 1'b0;
`endif
    logic       clk = 1'b0, reset = 1'b1, ld_req = 1'b0, st_req = 1'b0;
    logic [7:0] addr = '0, st_data = '0;
    register    ld_dst = rega;
    logic [7:0] loadData, l3_data;
    logic       loadEn, busy, req_err, l3_en, l3_busy, l3_err;
    register    loadDst, l3_dst;
    int         checks = 0, errors = 0;
    // model: a load accepted at edge N answers at edge N+RD_LAT+1; requests up to that edge are refused
    logic [7:0] mem [256];
    int         edge_n = 0, resp_edge = -1;
    logic [7:0] resp_data;
    register    resp_dst;
    logic       exp_en, exp_busy, exp_err;

    always #5 clk = ~clk;

    data_mem_unit #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset), .ld_req(ld_req), .st_req(st_req), .addr(addr), .st_data(st_data),
        .ld_dst(ld_dst), .loadData(loadData), .loadEn(loadEn), .loadDst(loadDst), .busy(busy), .req_err(req_err)
    );
    data_mem_unit #(.RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .ld_req(ld_req), .st_req(st_req), .addr(addr), .st_data(st_data),
        .ld_dst(ld_dst), .loadData(l3_data), .loadEn(l3_en), .loadDst(l3_dst), .busy(l3_busy), .req_err(l3_err)
    );

    task automatic drive_cycle(input logic ld, input logic st, input logic [7:0] a, input logic [7:0] d, input register r);
        logic refused;
        ld_req = ld; st_req = st; addr = a; st_data = d; ld_dst = r;
        @(posedge clk);
        refused = edge_n <= resp_edge;
        exp_err = refused ? (ld | st) : (ld & st);
        if (!refused) begin
            if (st) mem[a] = d;
            else if (ld) begin
                resp_edge = edge_n + RD_LAT + 1;
                resp_data = mem[a];
                resp_dst  = r;
            end
        end
        exp_en   = edge_n == resp_edge;
        exp_busy = edge_n < resp_edge;
        edge_n++;
        #1;
        ld_req = 1'b0; st_req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        resp_edge = -1;
    endtask

    task automatic wait_clear();
`ifdef DMEM_CLEAR_EN
        for (int i = 0; i < 300 && busy; i++) begin @(posedge clk); #1; end
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
`endif
    endtask

    task automatic wait_resp(output int lat, output logic [7:0] d, output register r, output int nbusy);
        lat = -1; d = '0; r = rega; nbusy = 0;
        for (int i = 1; i <= 10 && lat < 0; i++) begin
            drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, rega);
            if (busy) nbusy++;
            if (loadEn) begin lat = i; d = loadData; r = loadDst; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (loadData !== 8'h00 || loadEn !== 1'b0 || loadDst !== rega || busy !== RST_BUSY || req_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got data=%h en=%b dst=%0d busy=%b err=%b, want 00 0 0 %b 0",
                     loadData, loadEn, loadDst, busy, req_err, RST_BUSY);
        end
        reset = 1'b0;
        wait_clear();
    endtask

    task automatic test_store_load();
        int lat, nb, b0; logic [7:0] d; register r;
        drive_cycle(1'b0, 1'b1, 8'h10, 8'hA5, rega);
        checks++;
        if (busy !== 1'b0 || req_err !== 1'b0) begin
            errors++; $display("FAIL store_no_stall: busy=%b err=%b, want 0 0", busy, req_err);
        end
        drive_cycle(1'b1, 1'b0, 8'h10, 8'h00, regx);
        b0 = busy ? 1 : 0;
        wait_resp(lat, d, r, nb);
        checks++;
        if (lat !== RD_LAT + 1) begin errors++; $display("FAIL load_latency: got %0d, want %0d", lat, RD_LAT + 1); end
        checks++;
        if (d !== 8'hA5 || r !== regx) begin
            errors++; $display("FAIL load_data: got %h/%0d, want a5/%0d", d, r, regx);
        end
        checks++;
        if (b0 + nb !== RD_LAT + 1) begin errors++; $display("FAIL busy_cycles: got %0d, want %0d", b0 + nb, RD_LAT + 1); end
    endtask

    task automatic test_busy_req();
        int lat, nb; logic [7:0] d; register r;
        drive_cycle(1'b0, 1'b1, 8'h20, 8'h5C, rega);
        drive_cycle(1'b1, 1'b0, 8'h20, 8'h00, regb);
        drive_cycle(1'b0, 1'b1, 8'h20, 8'h11, rega);
        checks++;
        if (req_err !== 1'b1) begin errors++; $display("FAIL busy_req_err: got %b, want 1", req_err); end
        wait_resp(lat, d, r, nb);
        checks++;
        if (lat !== RD_LAT || d !== 8'h5C || r !== regb) begin
            errors++; $display("FAIL busy_inflight: got lat=%0d %h/%0d, want lat=%0d 5c/%0d", lat, d, r, RD_LAT, regb);
        end
        drive_cycle(1'b1, 1'b0, 8'h20, 8'h00, regc);
        wait_resp(lat, d, r, nb);
        checks++;
        if (d !== 8'h5C) begin errors++; $display("FAIL busy_store_dropped: got %h, want 5c", d); end
    endtask

    task automatic test_simultaneous();
        int lat, nb, pulses; logic [7:0] d; register r;
        drive_cycle(1'b1, 1'b1, 8'h33, 8'h7E, regc);
        checks++;
        if (req_err !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL simul_err: err=%b busy=%b, want 1 0", req_err, busy);
        end
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, rega);
            if (loadEn) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL simul_no_load: got %0d pulses, want 0", pulses); end
        drive_cycle(1'b1, 1'b0, 8'h33, 8'h00, regd);
        wait_resp(lat, d, r, nb);
        checks++;
        if (d !== 8'h7E || r !== regd) begin errors++; $display("FAIL simul_store: got %h/%0d, want 7e/%0d", d, r, regd); end
    endtask

    task automatic test_reset_mid_load();
        int lat, nb; logic [7:0] d; register r;
        drive_cycle(1'b1, 1'b0, 8'h10, 8'h00, regd);
        do_reset();
        checks++;
        if (loadEn !== 1'b0 || busy !== RST_BUSY) begin
            errors++; $display("FAIL midload_reset: en=%b busy=%b, want 0 %b", loadEn, busy, RST_BUSY);
        end
        wait_clear();
        drive_cycle(1'b1, 1'b0, 8'h10, 8'h00, rege);
        checks++;
        if (busy !== 1'b1 || req_err !== 1'b0) begin
            errors++; $display("FAIL midload_idle: busy=%b err=%b, want 1 0", busy, req_err);
        end
        wait_resp(lat, d, r, nb);
        checks++;
        if (lat !== RD_LAT + 1 || d !== mem[8'h10] || r !== rege) begin
            errors++; $display("FAIL midload_next: got lat=%0d %h/%0d, want lat=%0d %h/%0d", lat, d, r, RD_LAT + 1, mem[8'h10], rege);
        end
    endtask

    task automatic test_lat3();
        int lat, nb; logic [7:0] d;
        for (int i = 0; i < 6; i++) drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, rega);
        drive_cycle(1'b0, 1'b1, 8'h44, 8'hC3, rega);
        drive_cycle(1'b1, 1'b0, 8'h44, 8'h00, regf);
        nb = l3_busy ? 1 : 0;
        lat = -1; d = '0;
        for (int i = 1; i <= 8; i++) begin
            drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, rega);
            if (l3_busy) nb++;
            if (l3_en && lat < 0) begin lat = i; d = l3_data; end
        end
        checks++;
        if (lat !== 4 || d !== 8'hC3 || l3_dst !== regf) begin
            errors++; $display("FAIL lat3_load: got lat=%0d %h/%0d, want lat=4 c3/%0d", lat, d, l3_dst, regf);
        end
        checks++;
        if (nb !== 4 || l3_err !== 1'b0) begin errors++; $display("FAIL lat3_busy: got %0d err=%b, want 4 0", nb, l3_err); end
    endtask

    task automatic test_random();
        for (int a = 0; a < 256; a++) drive_cycle(1'b0, 1'b1, 8'(a), 8'($urandom), rega);
        for (int i = 0; i < 400; i++) begin
            drive_cycle(($urandom % 3) == 0, ($urandom % 3) == 0, 8'($urandom), 8'($urandom), register'(3'($urandom)));
            checks++;
            if (loadEn !== exp_en || busy !== exp_busy || req_err !== exp_err) begin
                errors++;
                $display("FAIL rand_ctrl@%0d: en/busy/err=%b%b%b, want %b%b%b", i, loadEn, busy, req_err, exp_en, exp_busy, exp_err);
            end
            if (exp_en) begin
                checks++;
                if (loadData !== resp_data || loadDst !== resp_dst) begin
                    errors++; $display("FAIL rand_data@%0d: got %h/%0d, want %h/%0d", i, loadData, loadDst, resp_data, resp_dst);
                end
            end
        end
        for (int i = 0; i < 6; i++) drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, rega);
    endtask

    task automatic test_clear();
`ifdef DMEM_CLEAR_EN
        int n, lat, nb; logic [7:0] d; register r;
        drive_cycle(1'b0, 1'b1, 8'hFF, 8'hFF, rega);
        do_reset();
        n = 0;
        for (int i = 0; i < 300 && busy; i++) begin
            n++;
            st_req = i == 5; addr = 8'h80; st_data = 8'h99;
            @(posedge clk); #1;
            if (i == 5) begin
                checks++;
                if (req_err !== 1'b1) begin errors++; $display("FAIL clear_req_err: got %b, want 1", req_err); end
            end
        end
        st_req = 1'b0;
        checks++;
        if (n !== 256) begin errors++; $display("FAIL clear_busy: got %0d cycles, want 256", n); end
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        drive_cycle(1'b1, 1'b0, 8'hFF, 8'h00, regg);
        wait_resp(lat, d, r, nb);
        checks++;
        if (lat !== RD_LAT + 1 || d !== 8'h00) begin errors++; $display("FAIL clear_data: got lat=%0d %h, want %0d 00", lat, d, RD_LAT + 1); end
`endif
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_busy_req();
        test_simultaneous();
        test_reset_mid_load();
        test_lat3();
        test_random();
        test_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
